// File: rtl/ibus_rom_responder.sv
// Instruction-bus ROM responder: answers iadr/isiz fetches from a word store after WAIT wait states.
// Define IBUS_ROM_FAULT_EN to ack misaligned and doubleword fetches with zero data.
module ibus_rom_responder #(
  parameter logic [63:0] BASE  = 64'hFFFF_FFFF_FFFF_FF00,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic        iack_o,
  output logic [31:0] idat_o,
  input  logic        ld_we_i,
  input  logic [9:0]  ld_adr_i,
  input  logic [31:0] ld_dat_i
);

  // state     | meaning
  // S_IDLE    | no request outstanding, accept on isiz_i != 0
  // S_WAITING | request latched, counting wait states down
  // S_ACK     | iack_o high for one cycle, always returns to S_IDLE

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd4;
  localparam logic [3:0]  WAIT4 = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [63:0] adr_q, adr_d;
  logic [1:0]  siz_q, siz_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] idat_q, idat_d;

  logic [31:0] mem [DEPTH];

  logic [63:0] rd_adr;
  logic [1:0]  rd_siz;
  logic [63:0] offset;
  logic        in_range;
  logic        fault;
  logic [31:0] word;
  logic [31:0] sel_dat;
  logic [31:0] rd_dat;
  logic        ld_adr_unused;

  assign ld_adr_unused = ^ld_adr_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      siz_q   <= '0;
      cnt_q   <= '0;
      idat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      siz_q   <= siz_d;
      cnt_q   <= cnt_d;
      idat_q  <= idat_d;
    end
  end

  // Store is never reset; loads are accepted in every state.
  always_ff @(posedge clk_i) begin
    if (ld_we_i)
      mem[ld_adr_i[AW-1:0]] <= ld_dat_i;
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    siz_d   = siz_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (isiz_i != 2'b00) begin
          adr_d   = iadr_i;
          siz_d   = isiz_i;
          cnt_d   = WAIT4;
          state_d = (WAIT == 0) ? S_ACK : S_WAITING;
        end
      end
      S_WAITING: begin
        if (isiz_i == 2'b00) begin
          state_d = S_IDLE;
        end else if (iadr_i != adr_q || isiz_i != siz_q) begin
          adr_d = iadr_i;
          siz_d = isiz_i;
          cnt_d = WAIT4;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With WAIT=0 the store is read on the accepting edge, so decode the live bus in IDLE.
  assign rd_adr   = (state_q == S_IDLE) ? iadr_i : adr_q;
  assign rd_siz   = (state_q == S_IDLE) ? isiz_i : siz_q;
  assign offset   = rd_adr - BASE;
  assign in_range = offset < SPAN;
  assign word     = mem[offset[AW+1:2]];

  always_comb begin
    sel_dat = word;
    if (rd_siz == 2'b01)
      sel_dat = offset[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
  end

`ifdef IBUS_ROM_FAULT_EN
  assign fault = (rd_siz == 2'b11) ||
                 (rd_siz == 2'b10 && offset[1:0] != 2'b00) ||
                 (rd_siz == 2'b01 && offset[0]);
`else
  assign fault = 1'b0;
`endif

  assign rd_dat = (in_range && !fault) ? sel_dat : 32'h0000_0000;

  always_comb begin
    idat_d = (state_d == S_ACK) ? rd_dat : 32'h0000_0000;
    iack_o = (state_q == S_ACK);
    idat_o = idat_q;
  end

endmodule

// File: tb/tb_ibus_rom_responder.sv
// Directed bench for ibus_rom_responder with default parameters (BASE ...FF00, DEPTH 64, WAIT 2).
// Fault-build expectations follow IBUS_ROM_FAULT_EN.
module tb_ibus_rom_responder;

  localparam int unsigned WAIT = 2;
  localparam logic [63:0] B    = 64'hFFFF_FFFF_FFFF_FF00;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_i;
  logic [1:0]  isiz_i;
  logic        iack_o;
  logic [31:0] idat_o;
  logic        ld_we_i;
  logic [9:0]  ld_adr_i;
  logic [31:0] ld_dat_i;

  int vectors = 0;
  int miscompares = 0;

  ibus_rom_responder #(.BASE(B), .DEPTH(64), .WAIT(WAIT)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .iadr_i   (iadr_i),
    .isiz_i   (isiz_i),
    .iack_o   (iack_o),
    .idat_o   (idat_o),
    .ld_we_i  (ld_we_i),
    .ld_adr_i (ld_adr_i),
    .ld_dat_i (ld_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] dat);
    ld_we_i  = 1'b1;
    ld_adr_i = 10'(idx);
    ld_dat_i = dat;
    edge1();
    ld_we_i  = 1'b0;
  endtask

  // Presents a request until the ack, checks latency (edges incl. the accepting one) and data,
  // then drops isiz and checks the ack lasted one cycle.
  task automatic fetch(input logic [63:0] adr, input logic [1:0] siz, input logic [31:0] exp,
                       input string tag);
    int n;
    n = 0;
    iadr_i = adr;
    isiz_i = siz;
    do begin
      edge1();
      n++;
    end while (!iack_o && n < 20);
    chk_vec({tag, "_lat"}, 64'(n), 64'(WAIT + 2));
    chk_vec({tag, "_dat"}, 64'(idat_o), 64'(exp));
    isiz_i = 2'b00;
    edge1();
    chk_vec({tag, "_drop"}, {31'd0, iack_o, idat_o}, 64'd0);
  endtask

  initial begin
    int n;
    int acks;
    logic [31:0] exp_w2, exp_h0b, exp_d08;

    reset_i  = 1'b1;
    iadr_i   = '0;
    isiz_i   = 2'b00;
    ld_we_i  = 1'b0;
    ld_adr_i = '0;
    ld_dat_i = '0;
    #3;
    chk_vec("rst_iack", 64'(iack_o), 64'd0);
    chk_vec("rst_idat", 64'(idat_o), 64'd0);
    edge1();
    edge1();
    reset_i = 1'b0;

    load(0, 32'h0000_0013);
    load(1, 32'h0010_0093);
    load(2, 32'hDEAD_BEEF);
    load(3, 32'h1111_1111);
    load(63, 32'h1234_5678);

    fetch(B + 64'h00, 2'b10, 32'h0000_0013, "boot");
    fetch(B + 64'h04, 2'b10, 32'h0010_0093, "seq");
    fetch(B + 64'hFC, 2'b10, 32'h1234_5678, "last_word");

    // Held request: ACK->IDLE edge, accepting edge, then WAIT+1 edges to the next ack.
    iadr_i = B + 64'h04;
    isiz_i = 2'b10;
    n = 0;
    do begin edge1(); n++; end while (!iack_o && n < 20);
    chk_vec("b2b_first_lat", 64'(n), 64'(WAIT + 2));
    n = 0;
    do begin edge1(); n++; end while (!iack_o && n < 20);
    chk_vec("b2b_period", 64'(n), 64'(WAIT + 3));
    chk_vec("b2b_dat", 64'(idat_o), 64'h0010_0093);
    isiz_i = 2'b00;
    edge1();
    chk_vec("b2b_drop", 64'(iack_o), 64'd0);

    // Abort after one wait cycle.
    iadr_i = B;
    isiz_i = 2'b10;
    edge1();
    edge1();
    isiz_i = 2'b00;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      if (iack_o) acks++;
    end
    chk_vec("abort_acks", 64'(acks), 64'd0);
    fetch(B, 2'b10, 32'h0000_0013, "post_abort");

    // Address change mid-wait relatches and restarts the count.
    iadr_i = B;
    isiz_i = 2'b10;
    edge1();
    edge1();
    fetch(B + 64'h04, 2'b10, 32'h0010_0093, "relatch");

    fetch(64'h0, 2'b10, 32'h0, "oor_zero");
    fetch(B - 64'h4, 2'b10, 32'h0, "oor_below");
    fetch(B + 64'h100, 2'b10, 32'h0, "oor_span");

    fetch(B + 64'h02, 2'b01, 32'h0000_0000, "hw_ff02");
    fetch(B + 64'h08, 2'b01, 32'h0000_BEEF, "hw_lo");
    fetch(B + 64'h0A, 2'b01, 32'h0000_DEAD, "hw_hi");

`ifdef IBUS_ROM_FAULT_EN
    exp_w2  = 32'h0;
    exp_h0b = 32'h0;
    exp_d08 = 32'h0;
    fetch(B + 64'h02, 2'b10, 32'h0, "mis_word0");
`else
    exp_w2  = 32'hDEAD_BEEF;
    exp_h0b = 32'h0000_DEAD;
    exp_d08 = 32'hDEAD_BEEF;
    fetch(B + 64'h02, 2'b10, 32'h0000_0013, "mis_word0");
`endif
    fetch(B + 64'h0A, 2'b10, exp_w2, "mis_word2");
    fetch(B + 64'h0B, 2'b01, exp_h0b, "mis_hw");
    fetch(B + 64'h08, 2'b11, exp_d08, "dword");

    // Load to the word being read on the same edge: ack carries the old value.
    iadr_i = B + 64'h0C;
    isiz_i = 2'b10;
    edge1();
    edge1();
    edge1();
    ld_we_i  = 1'b1;
    ld_adr_i = 10'd3;
    ld_dat_i = 32'h2222_2222;
    edge1();
    ld_we_i = 1'b0;
    chk_vec("rw_ack", 64'(iack_o), 64'd1);
    chk_vec("rw_old", 64'(idat_o), 64'h1111_1111);
    isiz_i = 2'b00;
    edge1();
    fetch(B + 64'h0C, 2'b10, 32'h2222_2222, "rw_new");

    // Asynchronous reset mid-wait.
    iadr_i = B;
    isiz_i = 2'b10;
    edge1();
    edge1();
    #3 reset_i = 1'b1;
    #1;
    chk_vec("rst_wait_iack", 64'(iack_o), 64'd0);
    isiz_i = 2'b00;
    edge1();
    reset_i = 1'b0;
    fetch(B, 2'b10, 32'h0000_0013, "post_rst_wait");

    // Asynchronous reset while acking drops iack/idat before the next edge.
    iadr_i = B + 64'h04;
    isiz_i = 2'b10;
    n = 0;
    do begin edge1(); n++; end while (!iack_o && n < 20);
    chk_vec("rst_ack_pre", {31'd0, iack_o, idat_o}, {31'd0, 1'b1, 32'h0010_0093});
    #2 reset_i = 1'b1;
    #1;
    chk_vec("rst_ack_iack", 64'(iack_o), 64'd0);
    chk_vec("rst_ack_idat", 64'(idat_o), 64'd0);
    isiz_i = 2'b00;
    edge1();
    reset_i = 1'b0;
    fetch(B, 2'b10, 32'h0000_0013, "post_rst_ack");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
